lstm_seq_ctrl: RTL
==================

Name: lstm_seq_ctrl

Overview:
- Timestep sequencer for one LSTM_node.
- Pulls per-timestep gate operand sets (i, c, f, o) from an upstream operand buffer via valid/ready.
- Drives the node inputs and status_in, waits for node completion, and feeds lstm_recu_out back as lstm_recu_in for the next step.
- Streams each step's lstm_node_out downstream; runs a configurable number of timesteps per start command.

Parameters:
- DW, 16, operand/result width (signed fixed point, 9 integer + 7 fraction bits).
- STEP_W, 8, width of the timestep count.
- TMO_W, 6, width of the completion-timeout counter.
- MAX_WAIT, 40, cycles allowed in WAIT before declaring timeout.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse; accepted only in IDLE
- num_steps  in  STEP_W  timesteps to run; sampled on accepted start
- op_valid  in  1  upstream gate operand set valid
- op_ready  out  1  controller accepts operand set
- op_i, op_c, op_f, op_o  in  DW each  gate operands
- node_in_i, node_in_c, node_in_f, node_in_o  out  DW each  to LSTM_node lstm_node_in_*.data
- node_recu_in  out  DW  to LSTM_node lstm_recu_in.data
- node_status_in  out  2  PE_STATE to node: 2'b00 IDLE, 2'b01 RUN
- node_status_out  in  2  LSTM_STATE from node; 2'b10 = DONE (outputs valid)
- node_out  in  DW  lstm_node_out.data
- node_recu_out  in  DW  lstm_recu_out.data
- res_valid  out  1  result valid
- res_ready  in  1  downstream accepts result
- res_data  out  DW  step result h_t
- res_last  out  1  marks final timestep result
- busy  out  1  high in any state but IDLE
- err_timeout  out  1  sticky; cleared only by reset or an accepted start

Behaviour:
- FSM states: IDLE, FETCH, WAIT, EMIT.
- Reset values:
  - state=IDLE; all node_* outputs 0; node_status_in=00.
  - op_ready=0, res_valid=0, res_last=0, res_data=0, busy=0, err_timeout=0.
  - Step counter 0; recurrent register 0.
- IDLE:
  - start with num_steps≠0: latch num_steps, clear step counter, recurrent reg=0 (h0=0), clear err_timeout, go to FETCH.
  - start with num_steps=0: ignored; state stays IDLE, no result emitted.
- FETCH:
  - op_ready=1.
  - On op_valid&op_ready: register operands to node_in_*, drive node_recu_in=recurrent reg, set node_status_in=01 from next cycle, clear timeout counter, go to WAIT.
  - Operands are held stable until leaving WAIT.
- WAIT:
  - node_status_in=01; timeout counter increments each cycle.
  - node_status_out==10: capture node_out→res_data and node_recu_out→recurrent reg, node_status_in=00, go to EMIT.
  - Counter reaches MAX_WAIT with no DONE: set err_timeout, node_status_in=00, abort to IDLE with no result. The step counter is discarded.
- EMIT:
  - res_valid=1; res_last=1 iff step counter==latched num_steps−1.
  - On res_ready: increment step counter; go to IDLE if last, else FETCH.
  - res_data and res_last are held stable while res_valid&&!res_ready.
- Latency: at least 1 cycle FETCH→WAIT; node DONE seen in cycle N of WAIT gives res_valid on the next cycle.
- start outside IDLE: ignored.
- Timestep count wraps are impossible: at most num_steps ≤ 2^STEP_W−1 steps.
- Reset mid-operation returns everything to reset values on the next edge. No partial result is emitted.

Optional Feature:
- LSTM_CTRL_PERF_EN defined: adds output perf_stall_cycles (32 bits).
  - Counts cycles spent in FETCH with op_valid=0 plus cycles in EMIT with res_ready=0.
  - Cleared on accepted start; saturates at all-ones.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package lstm_pkg holds:
  - PE_STATE encodings (PE_IDLE=2'b00, PE_RUN=2'b01).
  - LSTM_STATE DONE encoding (2'b10).
  - DW constant.
  - The FSM state enum.
- One sub-module, lstm_step_timer: the timeout counter with clear/enable and an expired flag.

Test Plan:
- num_steps=3, all operands 0x0014, node model asserts DONE after 4 WAIT cycles with node_out=0x0021 and recu_out=0x0021+k per step → three results.
  - res_last only on the 3rd result.
  - node_recu_in = 0 on step 1, then the previous recu_out on steps 2 and 3.
- op_valid low for 5 cycles in FETCH → op_ready held high, node_status_in=00, no WAIT entry.
  - With PERF_EN: perf_stall_cycles=5 at end.
- res_ready low for 3 cycles in EMIT → res_valid and res_data stable, step counter unchanged.
- Node never returns DONE → err_timeout=1 exactly MAX_WAIT cycles after WAIT entry, then IDLE, no res_valid.
  - A subsequent start clears err_timeout.
- reset asserted in WAIT of step 2 → next cycle: all outputs at reset values, busy=0.
  - A new start with num_steps=1 gives node_recu_in=0.
- start with num_steps=0, and start pulsed while busy → both ignored; state and results unchanged.

Source files
------------

// File: rtl/lstm_pkg.sv
// rtl/lstm_pkg.sv - shared encodings and FSM state type for the LSTM timestep sequencer
//
// Contents:
//   DW           operand/result width (signed Q9.7)
//   PE_IDLE/RUN  status_in encodings driven to the LSTM node
//   LSTM_DONE    status_out encoding meaning the node outputs are valid
//   ctrl_state_e sequencer FSM states
package lstm_pkg;

  localparam int DW = 16;

  localparam logic [1:0] PE_IDLE   = 2'b00;
  localparam logic [1:0] PE_RUN    = 2'b01;
  localparam logic [1:0] LSTM_DONE = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FETCH = 2'b01,
    ST_WAIT  = 2'b10,
    ST_EMIT  = 2'b11
  } ctrl_state_e;

endpackage

// File: rtl/lstm_step_timer.sv
// rtl/lstm_step_timer.sv - completion-timeout counter for one node evaluation
//
// Ports:
//   clock, reset  clock and synchronous active-high reset
//   clr           restart the count at zero (takes priority over en)
//   en            count this cycle (controller is waiting on the node)
//   expired       this enabled cycle is the last one allowed
module lstm_step_timer #(
  parameter int TMO_W    = 6,
  parameter int MAX_WAIT = 40
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  // The count is zero in the first waiting cycle, so cycle MAX_WAIT is the
  // one that sees LAST; the abort lands exactly MAX_WAIT cycles after entry.
  localparam logic [TMO_W-1:0] LAST = TMO_W'(MAX_WAIT - 1);

  logic [TMO_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign expired = en && (cnt_q == LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/lstm_seq_ctrl.sv
// rtl/lstm_seq_ctrl.sv - timestep sequencer feeding one LSTM node and streaming h_t results
//
// Optional build macro: LSTM_CTRL_PERF_EN adds perf_stall_cycles.
//
// Ports:
//   clock, reset          clock, synchronous active-high reset
//   start, num_steps      run request (accepted only when idle and num_steps != 0)
//   op_valid/op_ready     operand-set handshake, op_i/c/f/o gate operands
//   node_in_*, node_recu_in, node_status_in   drive the LSTM node
//   node_status_out, node_out, node_recu_out  node completion and results
//   res_valid/res_ready   result handshake, res_data h_t, res_last final step
//   busy                  not idle
//   err_timeout           sticky node-completion timeout
//   perf_stall_cycles     (macro only) upstream/downstream stall cycles
module lstm_seq_ctrl
  import lstm_pkg::*;
#(
  parameter int DW       = lstm_pkg::DW,
  parameter int STEP_W   = 8,
  parameter int TMO_W    = 6,
  parameter int MAX_WAIT = 40
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [STEP_W-1:0] num_steps,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [DW-1:0]     op_i,
  input  logic [DW-1:0]     op_c,
  input  logic [DW-1:0]     op_f,
  input  logic [DW-1:0]     op_o,
  output logic [DW-1:0]     node_in_i,
  output logic [DW-1:0]     node_in_c,
  output logic [DW-1:0]     node_in_f,
  output logic [DW-1:0]     node_in_o,
  output logic [DW-1:0]     node_recu_in,
  output logic [1:0]        node_status_in,
  input  logic [1:0]        node_status_out,
  input  logic [DW-1:0]     node_out,
  input  logic [DW-1:0]     node_recu_out,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DW-1:0]     res_data,
  output logic              res_last,
  output logic              busy,
  output logic              err_timeout
`ifdef LSTM_CTRL_PERF_EN
  ,
  output logic [31:0]       perf_stall_cycles
`endif
);

  ctrl_state_e       state_q, state_d;
  logic [STEP_W-1:0] num_q, num_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [DW-1:0]     recu_q, recu_d;
  logic [DW-1:0]     in_i_q, in_i_d, in_c_q, in_c_d, in_f_q, in_f_d, in_o_q, in_o_d;
  logic [DW-1:0]     recu_in_q, recu_in_d;
  logic [1:0]        status_q, status_d;
  logic [DW-1:0]     res_data_q, res_data_d;
  logic              err_q, err_d;

  logic accept_start, last_step, tmr_clr, tmr_en, tmr_expired;

  assign accept_start = (state_q == ST_IDLE) && start && (num_steps != '0);
  assign last_step    = (step_q == num_q - 1'b1);
  assign tmr_en       = (state_q == ST_WAIT);

  lstm_step_timer #(
    .TMO_W    (TMO_W),
    .MAX_WAIT (MAX_WAIT)
  ) u_timer (
    .clock   (clock),
    .reset   (reset),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .expired (tmr_expired)
  );

  always_comb begin
    state_d    = state_q;
    num_d      = num_q;
    step_d     = step_q;
    recu_d     = recu_q;
    in_i_d     = in_i_q;
    in_c_d     = in_c_q;
    in_f_d     = in_f_q;
    in_o_d     = in_o_q;
    recu_in_d  = recu_in_q;
    status_d   = status_q;
    res_data_d = res_data_q;
    err_d      = err_q;
    tmr_clr    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept_start) begin
          num_d   = num_steps;
          step_d  = '0;
          recu_d  = '0;  // h0 = 0
          err_d   = 1'b0;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (op_valid) begin
          in_i_d    = op_i;
          in_c_d    = op_c;
          in_f_d    = op_f;
          in_o_d    = op_o;
          recu_in_d = recu_q;
          status_d  = PE_RUN;
          tmr_clr   = 1'b1;
          state_d   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // DONE in the final allowed cycle still wins over the timeout.
        if (node_status_out == LSTM_DONE) begin
          res_data_d = node_out;
          recu_d     = node_recu_out;
          status_d   = PE_IDLE;
          state_d    = ST_EMIT;
        end else if (tmr_expired) begin
          err_d    = 1'b1;
          status_d = PE_IDLE;
          step_d   = '0;
          state_d  = ST_IDLE;
        end
      end
      ST_EMIT: begin
        if (res_ready) begin
          step_d  = step_q + 1'b1;
          state_d = last_step ? ST_IDLE : ST_FETCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      num_q      <= '0;
      step_q     <= '0;
      recu_q     <= '0;
      in_i_q     <= '0;
      in_c_q     <= '0;
      in_f_q     <= '0;
      in_o_q     <= '0;
      recu_in_q  <= '0;
      status_q   <= PE_IDLE;
      res_data_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      num_q      <= num_d;
      step_q     <= step_d;
      recu_q     <= recu_d;
      in_i_q     <= in_i_d;
      in_c_q     <= in_c_d;
      in_f_q     <= in_f_d;
      in_o_q     <= in_o_d;
      recu_in_q  <= recu_in_d;
      status_q   <= status_d;
      res_data_q <= res_data_d;
      err_q      <= err_d;
    end
  end

  assign op_ready       = (state_q == ST_FETCH);
  assign res_valid      = (state_q == ST_EMIT);
  assign res_last       = (state_q == ST_EMIT) && last_step;
  assign busy           = (state_q != ST_IDLE);
  assign res_data       = res_data_q;
  assign err_timeout    = err_q;
  assign node_in_i      = in_i_q;
  assign node_in_c      = in_c_q;
  assign node_in_f      = in_f_q;
  assign node_in_o      = in_o_q;
  assign node_recu_in   = recu_in_q;
  assign node_status_in = status_q;

`ifdef LSTM_CTRL_PERF_EN
  logic [31:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (accept_start) begin
      perf_d = '0;
    end else if (((state_q == ST_FETCH) && !op_valid) ||
                 ((state_q == ST_EMIT) && !res_ready)) begin
      if (perf_q != '1) perf_d = perf_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      perf_q <= '0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign perf_stall_cycles = perf_q;
`endif

endmodule
